// File: rtl/cmd_issue_sched_pkg.sv
// cmd_issue_sched_pkg: shared types for the SD command issue scheduler.
// Holds the response-type and command-source encodings, the FSM state type,
// the latched command struct and the fixed auto-command indices.
package cmd_issue_sched_pkg;

  typedef enum logic [1:0] {
    RSP_NONE       = 2'b00,
    RSP_LONG       = 2'b01,
    RSP_SHORT      = 2'b10,
    RSP_SHORT_BUSY = 2'b11
  } rsp_type_e;

  typedef enum logic [1:0] {
    SRC_SW   = 2'd0,
    SRC_AC12 = 2'd1,
    SRC_AC23 = 2'd2
  } cmd_src_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    rsp_type_e   rsp;
  } cmd_t;

  localparam logic [5:0] CMD12_IDX = 6'd12;
  localparam logic [5:0] CMD23_IDX = 6'd23;

endpackage

// File: rtl/cmd_issue_sched_if.sv
// cmd_issue_sched_if: handshake between the scheduler (master) and the
// SD command engine (slave). cmd is held stable from start until done.
interface cmd_issue_sched_if;
  import cmd_issue_sched_pkg::*;

  logic start;
  cmd_t cmd;
  logic done;
  logic err;

  modport master (output start, output cmd, input done, input err);
  modport slave  (input start, input cmd, output done, output err);
endinterface

// File: rtl/cmd_issue_sched_wdog.sv
// cmd_issue_sched_wdog: per-command completion watchdog.
// Counts cycles while en is high; expire flags the TO_CYCLES-th counted cycle.
module cmd_issue_sched_wdog #(
  parameter int TO_CYCLES = 1024,
  parameter int TO_W      = 11
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [TO_W-1:0] cnt;

  assign expire = en && (cnt == TO_W'(TO_CYCLES - 1));

  // Cleared before every wait so each command gets the full budget; saturates at expiry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (en && !expire)   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cmd_issue_sched.sv
// cmd_issue_sched: arbitrates software, Auto CMD12 and (optionally) Auto CMD23
// onto the single SD command engine, drives command inhibit and watchdogs
// each command. Optional feature macro: SDHCI_AUTO_CMD23_EN (Auto CMD23).
module cmd_issue_sched
  import cmd_issue_sched_pkg::*;
#(
  parameter int TO_CYCLES = 1024,
  parameter int TO_W      = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sw_valid_i,
  output logic              sw_ready_o,
  input  logic [5:0]        sw_idx_i,
  input  logic [31:0]       sw_arg_i,
  input  rsp_type_e         sw_rsp_i,
  input  logic              ac12_req_i,
  input  logic              ac23_req_i,
  input  logic [15:0]       blk_cnt_i,
  cmd_issue_sched_if.master eng,
  output logic              inhibit_o,
  output logic              sw_done_o,
  output logic              ac_done_o,
  output logic              ac_err_o,
  output logic              wdog_o
);
  sched_state_e state;
  cmd_src_e     src;
  logic ac12_pend, ac23_pend, ac12_any, ac23_any;
  logic grant_ac12, grant_ac23, grant_sw, wdog_exp;

  // A request pulse arriving in IDLE competes in the same cycle as the sticky flags
  assign ac12_any   = ac12_pend | ac12_req_i;
  assign grant_ac12 = (state == S_IDLE) & ac12_any;
  assign grant_ac23 = (state == S_IDLE) & ~ac12_any & ac23_any;
  assign grant_sw   = (state == S_IDLE) & ~ac12_any & ~ac23_any & sw_valid_i;

  // Ready must coincide with the grant cycle, so it is decoded from registered state
  assign sw_ready_o = grant_sw;

  // Sticky CMD12 request; on grant only a second, newer pulse survives
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         ac12_pend <= 1'b0;
    else if (grant_ac12) ac12_pend <= ac12_pend & ac12_req_i;
    else                 ac12_pend <= ac12_pend | ac12_req_i;
  end

`ifdef SDHCI_AUTO_CMD23_EN
  assign ac23_any = ac23_pend | ac23_req_i;

  // Sticky CMD23 request, same merge/re-arm rule as CMD12
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         ac23_pend <= 1'b0;
    else if (grant_ac23) ac23_pend <= ac23_pend & ac23_req_i;
    else                 ac23_pend <= ac23_pend | ac23_req_i;
  end
`else
  logic unused_ac23;
  assign unused_ac23 = ^{ac23_req_i, blk_cnt_i};
  assign ac23_pend   = 1'b0;
  assign ac23_any    = 1'b0;
`endif

  cmd_issue_sched_wdog #(.TO_CYCLES(TO_CYCLES), .TO_W(TO_W)) u_wdog (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (state == S_ISSUE),
    .en     (state == S_WAIT),
    .expire (wdog_exp)
  );

  // Command sequencer: grant, start, wait for completion or watchdog, report
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      src       <= SRC_SW;
      eng.start <= 1'b0;
      eng.cmd   <= '0;
      inhibit_o <= 1'b0;
      sw_done_o <= 1'b0;
      ac_done_o <= 1'b0;
      ac_err_o  <= 1'b0;
      wdog_o    <= 1'b0;
    end else begin
      eng.start <= 1'b0;
      sw_done_o <= 1'b0;
      ac_done_o <= 1'b0;
      ac_err_o  <= 1'b0;
      wdog_o    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_ac12 | grant_ac23 | grant_sw) begin
            state     <= S_ISSUE;
            eng.start <= 1'b1;
            inhibit_o <= 1'b1;
          end
          if (grant_ac12) begin
            src     <= SRC_AC12;
            eng.cmd <= '{idx: CMD12_IDX, arg: 32'h0, rsp: RSP_SHORT_BUSY};
          end else if (grant_ac23) begin
            src     <= SRC_AC23;
            eng.cmd <= '{idx: CMD23_IDX, arg: {16'h0, blk_cnt_i}, rsp: RSP_SHORT};
          end else if (grant_sw) begin
            src     <= SRC_SW;
            eng.cmd <= '{idx: sw_idx_i, arg: sw_arg_i, rsp: sw_rsp_i};
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          // A completion in the expiry cycle takes precedence over the watchdog
          if (eng.done) begin
            state <= S_DONE;
            if (src == SRC_SW) sw_done_o <= 1'b1;
            else begin
              ac_done_o <= 1'b1;
              ac_err_o  <= eng.err;
            end
          end else if (wdog_exp) begin
            state     <= S_IDLE;
            inhibit_o <= 1'b0;
            wdog_o    <= 1'b1;
            ac_err_o  <= (src != SRC_SW);
          end
        end
        default: begin
          state     <= S_IDLE;
          inhibit_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_issue_sched.sv
// tb_cmd_issue_sched: directed bench for the command issue scheduler
// (TO_CYCLES = 16). Inputs change 1ns after the rising edge, outputs are
// sampled on the falling edge. Covers SDHCI_AUTO_CMD23_EN either way.
module tb_cmd_issue_sched;
  import cmd_issue_sched_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sw_valid_i = 1'b0;
  logic        sw_ready_o;
  logic [5:0]  sw_idx_i = '0;
  logic [31:0] sw_arg_i = '0;
  rsp_type_e   sw_rsp_i = RSP_NONE;
  logic        ac12_req_i = 1'b0;
  logic        ac23_req_i = 1'b0;
  logic [15:0] blk_cnt_i = '0;
  logic        inhibit_o, sw_done_o, ac_done_o, ac_err_o, wdog_o;
  int checks = 0;
  int failures = 0;

  cmd_issue_sched_if eng ();

  cmd_issue_sched #(.TO_CYCLES(16), .TO_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .sw_valid_i(sw_valid_i), .sw_ready_o(sw_ready_o),
    .sw_idx_i(sw_idx_i), .sw_arg_i(sw_arg_i), .sw_rsp_i(sw_rsp_i),
    .ac12_req_i(ac12_req_i), .ac23_req_i(ac23_req_i), .blk_cnt_i(blk_cnt_i),
    .eng(eng), .inhibit_o(inhibit_o), .sw_done_o(sw_done_o),
    .ac_done_o(ac_done_o), .ac_err_o(ac_err_o), .wdog_o(wdog_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    eng.done = 1'b0; eng.err = 1'b0;
    rst_ni = 1'b0;
    step(); step(); smp();
    checks++;
    if ({eng.start, inhibit_o, sw_ready_o, sw_done_o, ac_done_o, ac_err_o, wdog_o} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {eng.start, inhibit_o, sw_ready_o, sw_done_o, ac_done_o, ac_err_o, wdog_o});
    end
    checks++;
    if (eng.cmd !== 40'h0) begin
      failures++; $display("FAIL reset_cmd: got %h expected 0", eng.cmd);
    end
    step(); rst_ni = 1'b1;
  endtask

  task automatic test_sw_cmd();
    step(); sw_valid_i = 1'b1; sw_idx_i = 6'd17; sw_arg_i = 32'h0000_0200; sw_rsp_i = RSP_SHORT;
    smp();
    checks++;
    if (sw_ready_o !== 1'b1 || eng.start !== 1'b0) begin
      failures++; $display("FAIL sw_grant: ready=%b start=%b expected 1 0", sw_ready_o, eng.start);
    end
    step(); sw_valid_i = 1'b0; smp();
    checks++;
    if (eng.start !== 1'b1 || eng.cmd.idx !== 6'd17 || eng.cmd.arg !== 32'h200 ||
        eng.cmd.rsp !== 2'b10 || inhibit_o !== 1'b1 || sw_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL sw_issue: start=%b idx=%0d arg=%h rsp=%b inh=%b rdy=%b expected 1 17 200 10 1 0",
               eng.start, eng.cmd.idx, eng.cmd.arg, eng.cmd.rsp, inhibit_o, sw_ready_o);
    end
    step(); smp();
    checks++;
    if (eng.start !== 1'b0 || inhibit_o !== 1'b1) begin
      failures++; $display("FAIL sw_wait: start=%b inh=%b expected 0 1", eng.start, inhibit_o);
    end
    step(); eng.done = 1'b1; smp();
    checks++;
    if (sw_done_o !== 1'b0) begin
      failures++; $display("FAIL sw_done_early: got %b expected 0", sw_done_o);
    end
    step(); eng.done = 1'b0; smp();
    checks++;
    if (sw_done_o !== 1'b1 || ac_done_o !== 1'b0 || inhibit_o !== 1'b1 || eng.cmd.idx !== 6'd17) begin
      failures++;
      $display("FAIL sw_done: sw_done=%b ac_done=%b inh=%b idx=%0d expected 1 0 1 17",
               sw_done_o, ac_done_o, inhibit_o, eng.cmd.idx);
    end
    step(); smp();
    checks++;
    if (sw_done_o !== 1'b0 || inhibit_o !== 1'b0) begin
      failures++; $display("FAIL sw_idle: sw_done=%b inh=%b expected 0 0", sw_done_o, inhibit_o);
    end
  endtask

  task automatic test_ac12_priority();
    step(); ac12_req_i = 1'b1; sw_valid_i = 1'b1;
    sw_idx_i = 6'd5; sw_arg_i = 32'h0000_AAAA; sw_rsp_i = RSP_LONG;
    smp();
    checks++;
    if (sw_ready_o !== 1'b0) begin
      failures++; $display("FAIL prio_no_ready: got %b expected 0", sw_ready_o);
    end
    step(); ac12_req_i = 1'b0; smp();
    checks++;
    if (eng.start !== 1'b1 || eng.cmd.idx !== 6'd12 || eng.cmd.arg !== 32'h0 ||
        eng.cmd.rsp !== 2'b11 || sw_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL prio_cmd12: start=%b idx=%0d arg=%h rsp=%b rdy=%b expected 1 12 0 11 0",
               eng.start, eng.cmd.idx, eng.cmd.arg, eng.cmd.rsp, sw_ready_o);
    end
    step(); eng.done = 1'b1; smp();
    step(); eng.done = 1'b0; smp();
    checks++;
    if (ac_done_o !== 1'b1 || ac_err_o !== 1'b0 || sw_done_o !== 1'b0 || sw_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL prio_ac_done: ac_done=%b ac_err=%b sw_done=%b rdy=%b expected 1 0 0 0",
               ac_done_o, ac_err_o, sw_done_o, sw_ready_o);
    end
    step(); smp();
    checks++;
    if (sw_ready_o !== 1'b1) begin
      failures++; $display("FAIL prio_sw_after: ready=%b expected 1", sw_ready_o);
    end
    step(); sw_valid_i = 1'b0; smp();
    checks++;
    if (eng.start !== 1'b1 || eng.cmd.idx !== 6'd5 || eng.cmd.arg !== 32'hAAAA || eng.cmd.rsp !== 2'b01) begin
      failures++;
      $display("FAIL prio_sw_issue: start=%b idx=%0d arg=%h rsp=%b expected 1 5 aaaa 01",
               eng.start, eng.cmd.idx, eng.cmd.arg, eng.cmd.rsp);
    end
    step(); eng.done = 1'b1;
    step(); eng.done = 1'b0; smp();
    checks++;
    if (sw_done_o !== 1'b1 || ac_done_o !== 1'b0) begin
      failures++; $display("FAIL prio_sw_done: sw_done=%b ac_done=%b expected 1 0", sw_done_o, ac_done_o);
    end
    step();
  endtask

  task automatic test_ac12_err();
    step(); ac12_req_i = 1'b1;
    step(); ac12_req_i = 1'b0;
    step(); eng.done = 1'b1; eng.err = 1'b1;
    step(); eng.done = 1'b0; eng.err = 1'b0; smp();
    checks++;
    if (ac_done_o !== 1'b1 || ac_err_o !== 1'b1 || sw_done_o !== 1'b0) begin
      failures++;
      $display("FAIL ac12_err: ac_done=%b ac_err=%b sw_done=%b expected 1 1 0", ac_done_o, ac_err_o, sw_done_o);
    end
    step(); smp();
    checks++;
    if (ac_err_o !== 1'b0 || inhibit_o !== 1'b0) begin
      failures++; $display("FAIL ac12_err_clear: ac_err=%b inh=%b expected 0 0", ac_err_o, inhibit_o);
    end
  endtask

  task automatic test_pending();
    step(); sw_valid_i = 1'b1; sw_idx_i = 6'd2; sw_arg_i = 32'h1; sw_rsp_i = RSP_SHORT;
    step(); sw_valid_i = 1'b0; ac12_req_i = 1'b1;
    step(); ac12_req_i = 1'b1;
    step(); ac12_req_i = 1'b0; eng.done = 1'b1;
    step(); eng.done = 1'b0; smp();
    checks++;
    if (sw_done_o !== 1'b1) begin
      failures++; $display("FAIL pend_sw_done: got %b expected 1", sw_done_o);
    end
    step(); smp();
    step(); smp();
    checks++;
    if (eng.start !== 1'b1 || eng.cmd.idx !== 6'd12) begin
      failures++; $display("FAIL pend_cmd12: start=%b idx=%0d expected 1 12", eng.start, eng.cmd.idx);
    end
    step(); eng.done = 1'b1;
    step(); eng.done = 1'b0; smp();
    checks++;
    if (ac_done_o !== 1'b1) begin
      failures++; $display("FAIL pend_ac_done: got %b expected 1", ac_done_o);
    end
    step(); smp();
    step(); smp();
    checks++;
    if (eng.start !== 1'b0 || inhibit_o !== 1'b0) begin
      failures++; $display("FAIL pend_merged: start=%b inh=%b expected 0 0", eng.start, inhibit_o);
    end
  endtask

  task automatic test_wdog();
    step(); ac12_req_i = 1'b1;
    step(); ac12_req_i = 1'b0;
    repeat (15) step();
    step(); smp();
    checks++;
    if (wdog_o !== 1'b0 || inhibit_o !== 1'b1) begin
      failures++; $display("FAIL wdog_early: wdog=%b inh=%b expected 0 1", wdog_o, inhibit_o);
    end
    step(); smp();
    checks++;
    if (wdog_o !== 1'b1 || ac_err_o !== 1'b1 || ac_done_o !== 1'b0 || inhibit_o !== 1'b0) begin
      failures++;
      $display("FAIL wdog_fire: wdog=%b ac_err=%b ac_done=%b inh=%b expected 1 1 0 0",
               wdog_o, ac_err_o, ac_done_o, inhibit_o);
    end
    step(); smp();
    checks++;
    if (wdog_o !== 1'b0 || eng.start !== 1'b0) begin
      failures++; $display("FAIL wdog_after: wdog=%b start=%b expected 0 0", wdog_o, eng.start);
    end
  endtask

  task automatic test_wdog_race();
    step(); sw_valid_i = 1'b1; sw_idx_i = 6'd8; sw_arg_i = 32'h1AA; sw_rsp_i = RSP_SHORT;
    step(); sw_valid_i = 1'b0;
    repeat (15) step();
    step(); eng.done = 1'b1;
    step(); eng.done = 1'b0; smp();
    checks++;
    if (sw_done_o !== 1'b1 || wdog_o !== 1'b0 || inhibit_o !== 1'b1) begin
      failures++;
      $display("FAIL wdog_race: sw_done=%b wdog=%b inh=%b expected 1 0 1", sw_done_o, wdog_o, inhibit_o);
    end
    step();
  endtask

  task automatic test_ignore_done();
    step(); eng.done = 1'b1; eng.err = 1'b1;
    step(); eng.done = 1'b0; eng.err = 1'b0; smp();
    checks++;
    if ({sw_done_o, ac_done_o, ac_err_o, inhibit_o, eng.start} !== 5'b0) begin
      failures++;
      $display("FAIL idle_done_ignored: got %b expected 00000",
               {sw_done_o, ac_done_o, ac_err_o, inhibit_o, eng.start});
    end
  endtask

  task automatic test_ac23();
`ifdef SDHCI_AUTO_CMD23_EN
    step(); ac23_req_i = 1'b1; blk_cnt_i = 16'h0008;
    step(); ac23_req_i = 1'b0; blk_cnt_i = 16'h0055; smp();
    checks++;
    if (eng.start !== 1'b1 || eng.cmd.idx !== 6'd23 || eng.cmd.arg !== 32'h8 || eng.cmd.rsp !== 2'b10) begin
      failures++;
      $display("FAIL ac23_issue: start=%b idx=%0d arg=%h rsp=%b expected 1 23 8 10",
               eng.start, eng.cmd.idx, eng.cmd.arg, eng.cmd.rsp);
    end
    step(); eng.done = 1'b1;
    step(); eng.done = 1'b0; smp();
    checks++;
    if (ac_done_o !== 1'b1 || ac_err_o !== 1'b0) begin
      failures++; $display("FAIL ac23_done: ac_done=%b ac_err=%b expected 1 0", ac_done_o, ac_err_o);
    end
    step();
    step(); ac12_req_i = 1'b1; ac23_req_i = 1'b1; blk_cnt_i = 16'h0003;
    step(); ac12_req_i = 1'b0; ac23_req_i = 1'b0; smp();
    checks++;
    if (eng.cmd.idx !== 6'd12) begin
      failures++; $display("FAIL ac23_prio_first: idx=%0d expected 12", eng.cmd.idx);
    end
    step(); eng.done = 1'b1;
    step(); eng.done = 1'b0;
    step();
    step(); smp();
    checks++;
    if (eng.start !== 1'b1 || eng.cmd.idx !== 6'd23 || eng.cmd.arg !== 32'h3) begin
      failures++;
      $display("FAIL ac23_prio_second: start=%b idx=%0d arg=%h expected 1 23 3", eng.start, eng.cmd.idx, eng.cmd.arg);
    end
    step(); eng.done = 1'b1;
    step(); eng.done = 1'b0;
    step();
`else
    step(); ac23_req_i = 1'b1; blk_cnt_i = 16'h0008;
    step(); ac23_req_i = 1'b0; smp();
    checks++;
    if (eng.start !== 1'b0 || inhibit_o !== 1'b0) begin
      failures++; $display("FAIL ac23_ignored: start=%b inh=%b expected 0 0", eng.start, inhibit_o);
    end
    step(); smp();
    checks++;
    if (eng.start !== 1'b0 || inhibit_o !== 1'b0) begin
      failures++; $display("FAIL ac23_ignored_late: start=%b inh=%b expected 0 0", eng.start, inhibit_o);
    end
`endif
  endtask

  task automatic test_reset_mid();
    step(); sw_valid_i = 1'b1; sw_idx_i = 6'd18; sw_arg_i = 32'hDEAD_BEEF; sw_rsp_i = RSP_SHORT;
    step(); sw_valid_i = 1'b0;
    step(); rst_ni = 1'b0; #1;
    checks++;
    if (inhibit_o !== 1'b0 || eng.cmd !== 40'h0 || eng.start !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: inh=%b cmd=%h start=%b expected 0 0 0", inhibit_o, eng.cmd, eng.start);
    end
    step(); rst_ni = 1'b1; eng.done = 1'b1;
    step(); eng.done = 1'b0; smp();
    checks++;
    if ({sw_done_o, ac_done_o, ac_err_o, wdog_o, inhibit_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_after: got %b expected 00000", {sw_done_o, ac_done_o, ac_err_o, wdog_o, inhibit_o});
    end
  endtask

  initial begin
    test_reset();
    test_sw_cmd();
    test_ac12_priority();
    test_ac12_err();
    test_pending();
    test_wdog();
    test_wdog_race();
    test_ignore_done();
    test_ac23();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
